// File: rtl/iso16_pkg.sv
// rtl/iso16_pkg.sv - shared state encoding and width helpers for the ISO-16 plugin collector
package iso16_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_ACCUM   = 3'd3,
      ST_FINAL   = 3'd4
   } state_e;

   localparam int DEFAULT_WARP_WIDTH  = 16;
   localparam int DEFAULT_ERROR_WIDTH = 32;
   localparam int MAX_PLUGINS         = 16;

   // Enough headroom for MAX_PLUGINS full-scale addends plus one guard bit.
   function automatic int acc_width(input int warp_width);
      return warp_width + 5;
   endfunction

endpackage

// File: rtl/iso16_plugin_collector_if.sv
// rtl/iso16_plugin_collector_if.sv - plugin-side and result-side signal bundle for the collector
interface iso16_plugin_collector_if
   import iso16_pkg::*;
#(
   parameter int NUM_PLUGINS = 4,
   parameter int WARP_WIDTH  = DEFAULT_WARP_WIDTH,
   parameter int ERROR_WIDTH = DEFAULT_ERROR_WIDTH
);
   logic                               req;
   logic                               plugin_start;
   logic [NUM_PLUGINS-1:0]             plugin_valid;
   logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x;
   logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y;
   logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z;
   logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error;
   logic                               busy;
   logic                               done;
   logic [WARP_WIDTH-1:0]              warp_sum_x;
   logic [WARP_WIDTH-1:0]              warp_sum_y;
   logic [WARP_WIDTH-1:0]              warp_sum_z;
   logic [ERROR_WIDTH-1:0]             error_sum;
   logic [NUM_PLUGINS-1:0]             valid_mask;
   logic                               timeout;

   modport master (
      input  req, plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
      output plugin_start, busy, done, warp_sum_x, warp_sum_y, warp_sum_z, error_sum,
             valid_mask, timeout
   );

   modport slave (
      output req, plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
      input  plugin_start, busy, done, warp_sum_x, warp_sum_y, warp_sum_z, error_sum,
             valid_mask, timeout
   );
endinterface

// File: rtl/iso16_sat_signed.sv
// rtl/iso16_sat_signed.sv - combinational clamp of a wide signed value into a narrower signed range
module iso16_sat_signed
   import iso16_pkg::*;
#(
   parameter int IN_WIDTH  = acc_width(DEFAULT_WARP_WIDTH),
   parameter int OUT_WIDTH = DEFAULT_WARP_WIDTH
) (
   input  logic signed [IN_WIDTH-1:0]  value,
   output logic signed [OUT_WIDTH-1:0] clamped
);
   localparam int EXT = IN_WIDTH - OUT_WIDTH;

   // The value fits when every bit from the output sign bit upward matches.
   logic [EXT:0] top_bits;
   assign top_bits = value[IN_WIDTH-1 -: EXT+1];

   always_comb begin
      clamped = value[OUT_WIDTH-1:0];
      if (!(top_bits == '0 || top_bits == '1)) begin
         if (value[IN_WIDTH-1]) clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         else                   clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end
endmodule

// File: rtl/iso16_plugin_collector.sv
// rtl/iso16_plugin_collector.sv - starts the ISO-16 plugins, gathers their results and sums them serially
module iso16_plugin_collector
   import iso16_pkg::*;
#(
   parameter int NUM_PLUGINS    = 4,
   parameter int WARP_WIDTH     = DEFAULT_WARP_WIDTH,
   parameter int ERROR_WIDTH    = DEFAULT_ERROR_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                      clk,
   input logic                      rst_n,
   iso16_plugin_collector_if.master bus
);
   localparam int AW = acc_width(WARP_WIDTH);
   localparam int EW = ERROR_WIDTH + 4;
   localparam int IW = (NUM_PLUGINS > 1) ? $clog2(NUM_PLUGINS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = ST_IDLE;
   localparam logic [2:0] S_START   = ST_START;
   localparam logic [2:0] S_COLLECT = ST_COLLECT;
   localparam logic [2:0] S_ACCUM   = ST_ACCUM;
   localparam logic [2:0] S_FINAL   = ST_FINAL;

   logic [2:0]              state;
   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [NUM_PLUGINS-1:0]  mask_q;
   logic                    to_q;
   logic signed [AW-1:0]    acc_x, acc_y, acc_z;
   logic [EW-1:0]           acc_e;
   logic                    start_q, done_q, timeout_q;
   logic [WARP_WIDTH-1:0]   sum_x_q, sum_y_q, sum_z_q;
   logic [ERROR_WIDTH-1:0]  sum_e_q;
   logic [NUM_PLUGINS-1:0]  mask_out_q;

   logic signed [WARP_WIDTH-1:0] cur_x, cur_y, cur_z, sat_x, sat_y, sat_z;
   logic [ERROR_WIDTH-1:0]       cur_e, sat_e;

   assign cur_x = bus.plugin_warp_x[int'(idx)*WARP_WIDTH +: WARP_WIDTH];
   assign cur_y = bus.plugin_warp_y[int'(idx)*WARP_WIDTH +: WARP_WIDTH];
   assign cur_z = bus.plugin_warp_z[int'(idx)*WARP_WIDTH +: WARP_WIDTH];
   assign cur_e = bus.plugin_error[int'(idx)*ERROR_WIDTH +: ERROR_WIDTH];

   iso16_sat_signed #(.IN_WIDTH(AW), .OUT_WIDTH(WARP_WIDTH)) u_sat_x (.value(acc_x), .clamped(sat_x));
   iso16_sat_signed #(.IN_WIDTH(AW), .OUT_WIDTH(WARP_WIDTH)) u_sat_y (.value(acc_y), .clamped(sat_y));
   iso16_sat_signed #(.IN_WIDTH(AW), .OUT_WIDTH(WARP_WIDTH)) u_sat_z (.value(acc_z), .clamped(sat_z));

   assign sat_e = (|acc_e[EW-1:ERROR_WIDTH]) ? '1 : acc_e[ERROR_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         mask_q     <= '0;
         to_q       <= 1'b0;
         acc_x      <= '0;
         acc_y      <= '0;
         acc_z      <= '0;
         acc_e      <= '0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         sum_x_q    <= '0;
         sum_y_q    <= '0;
         sum_z_q    <= '0;
         sum_e_q    <= '0;
         mask_out_q <= '0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt   <= '0;
               idx   <= '0;
               acc_x <= '0;
               acc_y <= '0;
               acc_z <= '0;
               acc_e <= '0;
               if (bus.req) begin
                  state   <= S_START;
                  start_q <= 1'b1;
               end
            end
            S_START: state <= S_COLLECT;
            S_COLLECT: begin
               // First COLLECT cycle is the plugins' latch cycle; the window runs TIMEOUT_CYCLES beyond it.
               cnt <= cnt + CW'(1);
               if (&bus.plugin_valid) begin
                  mask_q <= '1;
                  to_q   <= 1'b0;
                  state  <= S_ACCUM;
               end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
                  mask_q <= bus.plugin_valid;
                  to_q   <= 1'b1;
                  state  <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (mask_q[idx]) begin
                  acc_x <= acc_x + AW'(cur_x);
                  acc_y <= acc_y + AW'(cur_y);
                  acc_z <= acc_z + AW'(cur_z);
                  acc_e <= acc_e + EW'(cur_e);
               end
               idx <= idx + IW'(1);
               if (idx == IW'(NUM_PLUGINS - 1)) state <= S_FINAL;
            end
            S_FINAL: begin
               sum_x_q    <= sat_x;
               sum_y_q    <= sat_y;
               sum_z_q    <= sat_z;
               sum_e_q    <= sat_e;
               mask_out_q <= mask_q;
               timeout_q  <= to_q;
               done_q     <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.plugin_start = start_q;
   assign bus.busy         = (state != S_IDLE);
   assign bus.done         = done_q;
   assign bus.warp_sum_x   = sum_x_q;
   assign bus.warp_sum_y   = sum_y_q;
   assign bus.warp_sum_z   = sum_z_q;
   assign bus.error_sum    = sum_e_q;
   assign bus.valid_mask   = mask_out_q;
   assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_iso16_plugin_collector.sv
// tb/tb_iso16_plugin_collector.sv - self-checking bench for iso16_plugin_collector
module tb_iso16_plugin_collector;
   localparam int NP  = 4;
   localparam int WW  = 16;
   localparam int EWD = 32;
   localparam int TO  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   iso16_plugin_collector_if #(.NUM_PLUGINS(NP), .WARP_WIDTH(WW), .ERROR_WIDTH(EWD)) bus ();

   iso16_plugin_collector #(
      .NUM_PLUGINS(NP), .WARP_WIDTH(WW), .ERROR_WIDTH(EWD), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;
   int wx[NP], wy[NP], wz[NP];
   longint we[NP];
   logic [WW-1:0] exp_x, exp_y, exp_z;
   logic [EWD-1:0] exp_e;
   int done_edge, starts;
   bit busy0, busy_done;

   function automatic logic [WW-1:0] clamp_w(input longint s);
      longint hi, lo;
      hi = (longint'(1) << (WW - 1)) - 1;
      lo = -hi - 1;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      return s[WW-1:0];
   endfunction

   function automatic void model(input logic [NP-1:0] m);
      longint sx, sy, sz, se, emax;
      sx = 0; sy = 0; sz = 0; se = 0;
      emax = (longint'(1) << EWD) - 1;
      for (int i = 0; i < NP; i++) begin
         if (m[i]) begin
            sx += wx[i]; sy += wy[i]; sz += wz[i]; se += we[i];
         end
      end
      exp_x = clamp_w(sx);
      exp_y = clamp_w(sy);
      exp_z = clamp_w(sz);
      if (se > emax) se = emax;
      exp_e = se[EWD-1:0];
   endfunction

   task automatic apply_data();
      for (int i = 0; i < NP; i++) begin
         bus.plugin_warp_x[i*WW +: WW] = WW'(wx[i]);
         bus.plugin_warp_y[i*WW +: WW] = WW'(wy[i]);
         bus.plugin_warp_z[i*WW +: WW] = WW'(wz[i]);
         bus.plugin_error[i*EWD +: EWD] = EWD'(we[i]);
      end
   endtask

   task automatic set_delta();
      for (int i = 0; i < NP; i++) begin
         wx[i] = 6 * i; wy[i] = 2 * i; wz[i] = -i; we[i] = 4;
      end
      apply_data();
   endtask

   // Edge 0 is the edge that samples req; plugin_valid becomes vmask so that edge valid_edge samples it.
   task automatic do_op(input int valid_edge, input logic [NP-1:0] vmask);
      done_edge = -1; starts = 0; busy0 = 1'b0; busy_done = 1'b1;
      @(negedge clk);
      bus.plugin_valid = '0;
      bus.req = 1'b1;
      for (int e = 0; e < 60 && done_edge < 0; e++) begin
         @(posedge clk); #1;
         if (e == 0) begin
            bus.req = 1'b0;
            busy0 = bus.busy;
         end
         if (bus.plugin_start) starts++;
         if (bus.done) begin
            done_edge = e;
            busy_done = bus.busy;
         end
         if (e == valid_edge - 1) bus.plugin_valid = vmask;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({bus.plugin_start, bus.busy, bus.done, bus.timeout} !== 4'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 0000", {bus.plugin_start, bus.busy, bus.done, bus.timeout});
      end
      total++;
      if ({bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum, bus.valid_mask} !== '0) begin
         bad++;
         $display("FAIL reset_data: got %h want 0",
                  {bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum, bus.valid_mask});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_delta();
      set_delta();
      do_op(2, '1);
      total++;
      if (done_edge !== 7) begin bad++; $display("FAIL delta_done_edge: got %0d want 7", done_edge); end
      total++;
      if (starts !== 1) begin bad++; $display("FAIL delta_start_pulses: got %0d want 1", starts); end
      total++;
      if ({busy0, busy_done} !== 2'b10) begin
         bad++; $display("FAIL delta_busy: got %b want 10", {busy0, busy_done});
      end
      total++;
      if ({bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z} !== {16'd36, 16'd12, 16'hFFFA}) begin
         bad++; $display("FAIL delta_warp: got %h want 0024000cfffa",
                         {bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z});
      end
      total++;
      if ({bus.error_sum, bus.valid_mask, bus.timeout} !== {32'd16, 4'hF, 1'b0}) begin
         bad++; $display("FAIL delta_err_mask_to: got %h/%h/%b want 10/f/0",
                         bus.error_sum, bus.valid_mask, bus.timeout);
      end
   endtask

   task automatic test_timeout();
      set_delta();
      do_op(3, 4'hB);
      total++;
      if (done_edge !== 2 + TO + NP + 1) begin
         bad++; $display("FAIL timeout_done_edge: got %0d want %0d", done_edge, 2 + TO + NP + 1);
      end
      total++;
      if ({bus.timeout, bus.valid_mask} !== {1'b1, 4'hB}) begin
         bad++; $display("FAIL timeout_flag_mask: got %b/%h want 1/b", bus.timeout, bus.valid_mask);
      end
      total++;
      if ({bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum} !== {16'd24, 16'd8, 16'hFFFC, 32'd12}) begin
         bad++; $display("FAIL timeout_sums: got %h want 00180008fffc0000000c",
                         {bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum});
      end
   endtask

   task automatic test_terminal_valid();
      set_delta();
      do_op(2 + TO, '1);
      total++;
      if ({done_edge, bus.timeout, bus.valid_mask, bus.warp_sum_x} !== {2 + TO + NP + 1, 1'b0, 4'hF, 16'd36}) begin
         bad++; $display("FAIL terminal_valid: got edge=%0d to=%b mask=%h x=%h want edge=%0d to=0 mask=f x=0024",
                         done_edge, bus.timeout, bus.valid_mask, bus.warp_sum_x, 2 + TO + NP + 1);
      end
      do_op(3 + TO, '1);
      total++;
      if ({done_edge, bus.timeout, bus.valid_mask, bus.warp_sum_x, bus.error_sum} !==
          {2 + TO + NP + 1, 1'b1, 4'h0, 16'd0, 32'd0}) begin
         bad++; $display("FAIL late_valid: got edge=%0d to=%b mask=%h x=%h e=%h want edge=%0d to=1 mask=0 x=0 e=0",
                         done_edge, bus.timeout, bus.valid_mask, bus.warp_sum_x, bus.error_sum, 2 + TO + NP + 1);
      end
   endtask

   task automatic test_saturation();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < NP; i++) begin
            wx[i] = (pass == 0) ? 32767 : -32768;
            wy[i] = int'($urandom_range(0, 65535)) - 32768;
            wz[i] = int'($urandom_range(0, 2000)) - 1000;
            we[i] = (pass == 0) ? 64'hFFFF_FFF0 : longint'($urandom_range(0, 1000));
         end
         apply_data();
         model('1);
         do_op(2, '1);
         total++;
         if (bus.warp_sum_x !== ((pass == 0) ? 16'h7FFF : 16'h8000)) begin
            bad++; $display("FAIL sat_x pass%0d: got %h want %h", pass, bus.warp_sum_x,
                            (pass == 0) ? 16'h7FFF : 16'h8000);
         end
         total++;
         if ({bus.warp_sum_y, bus.warp_sum_z, bus.error_sum} !== {exp_y, exp_z, exp_e}) begin
            bad++; $display("FAIL sat_yze pass%0d: got %h want %h", pass,
                            {bus.warp_sum_y, bus.warp_sum_z, bus.error_sum}, {exp_y, exp_z, exp_e});
         end
      end
      total++;
      if (exp_e === 32'hFFFF_FFFF || bus.error_sum === 32'hFFFF_FFFF) begin
         bad++; $display("FAIL sat_err_release: got %h want unsaturated %h", bus.error_sum, exp_e);
      end
   endtask

   task automatic test_req_held();
      int d1, d2;
      set_delta();
      d1 = -1; d2 = -1; starts = 0;
      @(negedge clk);
      bus.plugin_valid = '1;
      bus.req = 1'b1;
      for (int e = 0; e < 16; e++) begin
         @(posedge clk); #1;
         if (bus.plugin_start) starts++;
         if (bus.done) begin
            if (d1 < 0) d1 = e; else d2 = e;
         end
         if (e == 15) bus.req = 1'b0;
      end
      total++;
      if (starts !== 2) begin bad++; $display("FAIL req_held_starts: got %0d want 2", starts); end
      total++;
      if ({d1, d2} !== {32'd7, 32'd15}) begin
         bad++; $display("FAIL req_held_done_edges: got %0d,%0d want 7,15", d1, d2);
      end
      total++;
      if (bus.warp_sum_x !== 16'd36) begin
         bad++; $display("FAIL req_held_x: got %h want 0024", bus.warp_sum_x);
      end
   endtask

   task automatic test_reset_mid();
      set_delta();
      @(negedge clk);
      bus.plugin_valid = '0;
      bus.req = 1'b1;
      for (int e = 0; e < 5; e++) begin
         @(posedge clk); #1;
         if (e == 0) bus.req = 1'b0;
         if (e == 1) bus.plugin_valid = '1;
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.plugin_start, bus.busy, bus.done, bus.timeout, bus.valid_mask,
           bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum} !== '0) begin
         bad++; $display("FAIL reset_mid_outputs: got %h want 0",
                         {bus.plugin_start, bus.busy, bus.done, bus.timeout, bus.valid_mask,
                          bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum});
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2, '1);
      total++;
      if ({done_edge, bus.warp_sum_x, bus.error_sum} !== {32'd7, 16'd36, 32'd16}) begin
         bad++; $display("FAIL reset_mid_rerun: got edge=%0d x=%h e=%h want edge=7 x=0024 e=10",
                         done_edge, bus.warp_sum_x, bus.error_sum);
      end
   endtask

   task automatic test_random();
      int ve, end_e;
      logic [NP-1:0] vm, m;
      logic t;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < NP; i++) begin
            wx[i] = int'($urandom_range(0, 65535)) - 32768;
            wy[i] = int'($urandom_range(0, 65535)) - 32768;
            wz[i] = int'($urandom_range(0, 400)) - 200;
            we[i] = longint'($urandom);
         end
         apply_data();
         ve = int'($urandom_range(2, 3 + TO));
         vm = ($urandom_range(0, 1) == 1) ? '1 : NP'($urandom);
         if (vm == '1 && ve <= 2 + TO) begin
            end_e = ve; t = 1'b0; m = '1;
         end else begin
            end_e = 2 + TO; t = 1'b1; m = (ve <= 2 + TO) ? vm : '0;
         end
         model(m);
         do_op(ve, vm);
         total++;
         if ({done_edge, bus.timeout, bus.valid_mask} !== {end_e + NP + 1, t, m}) begin
            bad++; $display("FAIL rand%0d_ctrl: got edge=%0d to=%b mask=%h want edge=%0d to=%b mask=%h",
                            it, done_edge, bus.timeout, bus.valid_mask, end_e + NP + 1, t, m);
         end
         total++;
         if ({bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum} !== {exp_x, exp_y, exp_z, exp_e}) begin
            bad++; $display("FAIL rand%0d_sums: got %h want %h", it,
                            {bus.warp_sum_x, bus.warp_sum_y, bus.warp_sum_z, bus.error_sum},
                            {exp_x, exp_y, exp_z, exp_e});
         end
      end
   endtask

   initial begin
      bus.req = 1'b0;
      bus.plugin_valid = '0;
      bus.plugin_warp_x = '0;
      bus.plugin_warp_y = '0;
      bus.plugin_warp_z = '0;
      bus.plugin_error = '0;
      test_reset();
      test_delta();
      test_timeout();
      test_terminal_valid();
      test_saturation();
      test_reset_mid();
      test_req_held();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
